// File: rtl/psx_pad_reader.sv
// ============================================================================
// psx_pad_reader : polls a PlayStation digital/analog pad, returns buttons/ID
// Rev 1.0
// ============================================================================
`default_nettype none

module psx_pad_reader #(
  parameter int CLK_HZ  = 25_200_000,
  parameter int SCK_HZ  = 250_000,
  parameter int POLL_HZ = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        joyi,
  output logic [2:0]  joy,
  output logic [15:0] btn,
  output logic [7:0]  id,
  output logic        valid,
  output logic        err
);

  localparam int HALF = CLK_HZ / SCK_HZ / 2;
  localparam int POLL = CLK_HZ / POLL_HZ;
  localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PC_W = (POLL > 1) ? $clog2(POLL) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [HC_W-1:0] hc_q, hc_d;
  logic [PC_W-1:0] poll_q, poll_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  b2_q, b2_d;
  logic [7:0]  b3_q, b3_d;
  logic [2:0]  joy_q, joy_d;
  logic [15:0] btn_q, btn_d;
  logic [7:0]  id_q, id_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [1:0]  sync_q, sync_d;
  logic        tick;
  logic        poll_wrap;

  // Command byte sequence 0x01, 0x42, then zeros; returns one bit of it.
  function automatic logic cmd_bit(input logic [2:0] b, input logic [2:0] i);
    logic [7:0] c;
    case (b)
      3'd0:    c = 8'h01;
      3'd1:    c = 8'h42;
      default: c = 8'h00;
    endcase
    return c[i];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    rx_d    = rx_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    b3_d    = b3_q;
    joy_d   = joy_q;
    btn_d   = btn_q;
    id_d    = id_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    sync_d  = {sync_q[0], joyi};

    tick      = (state_q != S_IDLE) && (hc_q == HC_W'(HALF - 1));
    poll_wrap = (poll_q == PC_W'(POLL - 1));
    poll_d    = poll_wrap ? '0 : poll_q + 1'b1;
    hc_d      = ((state_q == S_IDLE) || tick) ? '0 : hc_q + 1'b1;

    // joy = {CMD, SEL, CLK}
    case (state_q)
      S_IDLE: begin
        joy_d = 3'b111;
        if (poll_wrap) begin
          state_d = S_SETUP;
          cnt_d   = 2'd0;
          joy_d   = 3'b101;
        end
      end
      S_SETUP: begin
        if (tick) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_LOW;
            bit_d   = 3'd0;
            byte_d  = 3'd0;
            joy_d   = {cmd_bit(3'd0, 3'd0), 2'b00};
          end
        end
      end
      S_LOW: begin
        if (tick) begin
          state_d     = S_HIGH;
          joy_d[0]    = 1'b1;
          rx_d[bit_q] = sync_q[1];
        end
      end
      S_HIGH: begin
        if (tick) begin
          if (bit_q != 3'd7) begin
            state_d = S_LOW;
            bit_d   = bit_q + 3'd1;
            joy_d   = {cmd_bit(byte_q, bit_q + 3'd1), 2'b00};
          end else if (byte_q != 3'd4) begin
            state_d = S_GAP;
            cnt_d   = 2'd0;
            joy_d   = 3'b101;
            case (byte_q)
              3'd1:    b1_d = rx_q;
              3'd2:    b2_d = rx_q;
              3'd3:    b3_d = rx_q;
              default: ;
            endcase
          end else begin
            // Last bit of byte 4 is already in rx_q; publish the result now.
            state_d = S_DONE;
            joy_d   = 3'b111;
            valid_d = 1'b1;
            id_d    = b1_q;
            if (b2_q == 8'h5A) begin
              btn_d = {~rx_q, ~b3_q};
            end else begin
              btn_d = 16'h0000;
              err_d = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_LOW;
            bit_d   = 3'd0;
            byte_d  = byte_q + 3'd1;
            joy_d   = {cmd_bit(byte_q + 3'd1, 3'd0), 2'b00};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        joy_d   = 3'b111;
      end
      default: begin
        state_d = S_IDLE;
        joy_d   = 3'b111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hc_q    <= '0;
      poll_q  <= '0;
      cnt_q   <= 2'd0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      rx_q    <= 8'h00;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      b3_q    <= 8'h00;
      joy_q   <= 3'b111;
      btn_q   <= 16'h0000;
      id_q    <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      poll_q  <= poll_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      rx_q    <= rx_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      b3_q    <= b3_d;
      joy_q   <= joy_d;
      btn_q   <= btn_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      sync_q  <= sync_d;
    end
  end

  assign joy   = joy_q;
  assign btn   = btn_q;
  assign id    = id_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_psx_pad_reader.sv
// ============================================================================
// tb_psx_pad_reader : randomized pad replies checked against a transaction model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_psx_pad_reader;

  localparam int CLK_HZ  = 1_000_000;
  localparam int SCK_HZ  = 250_000;
  localparam int POLL_HZ = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        joyi = 1'b1;
  logic [2:0]  joy;
  logic [15:0] btn;
  logic [7:0]  id;
  logic        valid;
  logic        err;

  always #5 clk = ~clk;

  psx_pad_reader #(
    .CLK_HZ (CLK_HZ),
    .SCK_HZ (SCK_HZ),
    .POLL_HZ(POLL_HZ)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .joyi (joyi),
    .joy  (joy),
    .btn  (btn),
    .id   (id),
    .valid(valid),
    .err  (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pad model and bus monitor state
  logic [7:0]  reply [5];
  bit          pad_on = 1'b1;
  int          bitn = 0;
  logic        prev_clk = 1'b1;
  logic        prev_sel = 1'b1;
  logic [39:0] cap = '0;
  int          falls = 0;
  int          cyc = 0;
  bit          fell, rose;
  logic [15:0] exp_btn = 16'h0000;
  logic [7:0]  exp_id = 8'h00;
  int          last_tf = 0;

  // One clock: observe the bus at the falling edge and play the pad's part.
  // The pad shifts out its next bit after each rising CLK so it is settled
  // well before the following rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    fell = prev_sel && !joy[1];
    rose = !prev_sel && joy[1];
    if (fell) begin
      bitn  = 0;
      falls = 0;
      cap   = '0;
      joyi  = pad_on ? reply[0][0] : 1'b1;
    end else if (rose) begin
      joyi = 1'b1;
    end
    if (!joy[1] && !prev_clk && joy[0]) begin
      if (bitn < 40) cap[bitn] = joy[2];
      bitn++;
      joyi = (pad_on && bitn < 40) ? reply[bitn / 8][bitn % 8] : 1'b1;
    end
    if (!joy[1] && prev_clk && !joy[0]) falls++;
    prev_clk = joy[0];
    prev_sel = joy[1];
  endtask

  task automatic txn(input string tag, input int refc, input int exp_gap);
    int          tf, tv;
    bit          held, early;
    logic [7:0]  rb [5];
    logic        e_err;
    logic [15:0] e_btn;
    tf = -1; tv = -1; held = 1'b1; early = 1'b0;
    for (int i = 0; i < 2500 && tf < 0; i++) begin
      step();
      if (valid) early = 1'b1;
      if (btn !== exp_btn || id !== exp_id) held = 1'b0;
      if (fell) tf = cyc;
    end
    if (tf < 0) begin
      check({tag, " start_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, " start_delay"}, 64'(tf - refc), 64'(exp_gap));
    for (int i = 0; i < 400 && tv < 0; i++) begin
      step();
      if (valid) tv = cyc;
      else if (btn !== exp_btn || id !== exp_id) held = 1'b0;
    end
    if (tv < 0) begin
      check({tag, " valid_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, " valid_delay"}, 64'(tv - tf), 64'd200);
    check({tag, " sel_rise_at_valid"}, {63'd0, rose}, 64'd1);
    check({tag, " early_valid_or_unheld"}, {62'd0, early, held}, 64'd1);
    check({tag, " cmd_bytes"}, {24'd0, cap}, {24'd0, 8'h00, 8'h00, 8'h00, 8'h42, 8'h01});
    check({tag, " clk_falls"}, 64'(falls), 64'd40);

    for (int k = 0; k < 5; k++) rb[k] = pad_on ? reply[k] : 8'hFF;
    if (rb[2] == 8'h5A) begin
      e_btn = {~rb[4], ~rb[3]};
      e_err = 1'b0;
    end else begin
      e_btn = 16'h0000;
      e_err = 1'b1;
    end
    check({tag, " btn"}, {48'd0, btn}, {48'd0, e_btn});
    check({tag, " id"}, {56'd0, id}, {56'd0, rb[1]});
    check({tag, " err"}, {63'd0, err}, {63'd0, e_err});
    exp_btn = e_btn;
    exp_id  = rb[1];
    step();
    check({tag, " pulse_width"}, {62'd0, valid, err}, 64'd0);
    last_tf = tf;
  endtask

  initial begin
    int rel, tf;
    reply[0] = 8'hFF; reply[1] = 8'h41; reply[2] = 8'h5A; reply[3] = 8'hFE; reply[4] = 8'hBF;

    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rst joy", {61'd0, joy}, 64'h7);
    check("rst btn_id", {40'd0, btn, id}, 64'd0);
    check("rst valid_err", {62'd0, valid, err}, 64'd0);
    rst = 1'b0;
    rel = cyc;

    txn("first", rel, 1000);

    pad_on = 1'b0;
    txn("nopad", last_tf, 1000);
    pad_on = 1'b1;
    txn("restore", last_tf, 1000);

    reply[0] = 8'hFF; reply[1] = 8'h73; reply[2] = 8'h5A; reply[3] = 8'h00; reply[4] = 8'h00;
    txn("analog", last_tf, 1000);

    for (int n = 0; n < 6; n++) begin
      reply[0] = 8'($urandom);
      reply[1] = ($urandom_range(0, 1) == 0) ? 8'h41 : 8'h73;
      reply[2] = ($urandom_range(0, 3) != 0) ? 8'h5A : 8'($urandom);
      reply[3] = 8'($urandom);
      reply[4] = 8'($urandom);
      txn("random", last_tf, 1000);
    end

    // Reset pulse in the middle of a transaction
    tf = -1;
    for (int i = 0; i < 2500 && tf < 0; i++) begin
      step();
      if (fell) tf = cyc;
    end
    if (tf < 0) begin
      check("midrst start_timeout", 64'd0, 64'd1);
    end else begin
      while (cyc < tf + 60) step();
      check("midrst sel_active", {63'd0, joy[1]}, 64'd0);
      rst = 1'b1;
      step();
      check("midrst joy", {61'd0, joy}, 64'h7);
      check("midrst no_pulse", {62'd0, valid, err}, 64'd0);
      check("midrst btn_id", {40'd0, btn, id}, 64'd0);
      rst = 1'b0;
      rel = cyc;
      exp_btn = 16'h0000;
      exp_id  = 8'h00;
      txn("after_rst", rel, 1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
